ysyx_22040088_lsu: RTL and testbench

Multi-cycle load/store unit that consumes the control unit's memory controls (`mem_ena`, `mem_wen`, `mem_mask`, `sel_rfres`). It turns one decoded memory instruction into exactly one transaction on a 64-bit aligned data bus. It sits between the execute stage (ALU address, rs2 data) and the data memory. It stalls the core until the transaction completes, then returns the lane-aligned, sign- or zero-extended load result for writeback.

---
 rtl/ysyx_22040088_lsu_pkg.sv | 66 ++++++
 rtl/ysyx_22040088_lsu_align.sv | 58 +++++
 rtl/ysyx_22040088_lsu.sv | 149 ++++++++++++++
 tb/tb_ysyx_22040088_lsu.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040088_lsu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22040088_lsu_pkg
// Shared definitions for the load/store unit:
//   - mem_mask one-hot size encodings (MASK_D/W/H/B)
//   - sel_rfres bit indices for signed / unsigned loads
//   - LSU FSM state encoding and internal access-size encoding
//   - helpers to decode the size mask and check natural alignment
// ---------------------------------------------------------------------------
package ysyx_22040088_lsu_pkg;

  localparam int XLEN = 64;

  // mem_mask encodings (one-hot)
  localparam logic [3:0] MASK_D = 4'b0001;  // 8 bytes
  localparam logic [3:0] MASK_W = 4'b0010;  // 4 bytes
  localparam logic [3:0] MASK_H = 4'b0100;  // 2 bytes
  localparam logic [3:0] MASK_B = 4'b1000;  // 1 byte

  // sel_rfres bit positions
  localparam int SEL_SIGNED   = 1;
  localparam int SEL_UNSIGNED = 2;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // log2 of the access size in bytes
  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } lsu_size_e;

  function automatic logic mask_legal(input logic [3:0] mask);
    return (mask == MASK_D) || (mask == MASK_W) ||
           (mask == MASK_H) || (mask == MASK_B);
  endfunction

  // Illegal masks decode to SIZE_D; they never reach the bus anyway.
  function automatic lsu_size_e mask_to_size(input logic [3:0] mask);
    lsu_size_e size;
    case (mask)
      MASK_B:  size = SIZE_B;
      MASK_H:  size = SIZE_H;
      MASK_W:  size = SIZE_W;
      default: size = SIZE_D;
    endcase
    return size;
  endfunction

  function automatic logic misaligned(input lsu_size_e size, input logic [2:0] off);
    logic bad;
    case (size)
      SIZE_H:  bad = off[0];
      SIZE_W:  bad = |off[1:0];
      SIZE_D:  bad = |off;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_22040088_lsu_align.sv
// ---------------------------------------------------------------------------
// ysyx_22040088_lsu_align
// Purely combinational byte-lane steering for a 64-bit aligned data bus.
//   offset    in  3 : byte offset of the access inside the 8-byte word
//   size      in  2 : access size (lsu_size_e)
//   is_signed in  1 : sign-extend the load result (else zero-extend)
//   st_data   in 64 : right-justified store data
//   st_wstrb  out 8 : byte strobes for the store
//   st_wdata  out 64: store data shifted to its lanes
//   ld_rdata  in 64 : raw bus read data
//   ld_result out 64: extracted and extended load value
// ---------------------------------------------------------------------------
module ysyx_22040088_lsu_align
  import ysyx_22040088_lsu_pkg::*;
(
  input  logic [2:0]  offset,
  input  lsu_size_e   size,
  input  logic        is_signed,
  input  logic [63:0] st_data,
  output logic [7:0]  st_wstrb,
  output logic [63:0] st_wdata,
  input  logic [63:0] ld_rdata,
  output logic [63:0] ld_result
);

  logic [5:0]  shamt;
  logic [7:0]  size_strb;
  logic [63:0] raw;

  assign shamt = {offset, 3'b000};

  always_comb begin
    size_strb = 8'h00;
    case (size)
      SIZE_B:  size_strb = 8'h01;
      SIZE_H:  size_strb = 8'h03;
      SIZE_W:  size_strb = 8'h0F;
      default: size_strb = 8'hFF;
    endcase
  end

  // Aligned accesses never push strobes past bit 7, so the 8-bit shift is exact.
  assign st_wstrb = size_strb << offset;
  assign st_wdata = st_data << shamt;

  assign raw = ld_rdata >> shamt;

  always_comb begin
    ld_result = raw;
    case (size)
      SIZE_B:  ld_result = is_signed ? {{56{raw[7]}},  raw[7:0]}  : {56'd0, raw[7:0]};
      SIZE_H:  ld_result = is_signed ? {{48{raw[15]}}, raw[15:0]} : {48'd0, raw[15:0]};
      SIZE_W:  ld_result = is_signed ? {{32{raw[31]}}, raw[31:0]} : {32'd0, raw[31:0]};
      default: ld_result = raw;
    endcase
  end

endmodule

// File: rtl/ysyx_22040088_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_22040088_lsu
// Multi-cycle load/store unit: one decoded memory instruction becomes exactly
// one transaction on a 64-bit aligned request/response bus. The core is
// stalled until the transaction completes.
//   clk, rst_n          : clock, asynchronous active-low reset
//   mem_ena/mem_wen     : memory instruction present / store
//   mem_mask            : one-hot access size
//   sel_rfres           : bit1 signed load, bit2 unsigned load
//   addr, wdata         : effective address, right-justified store data
//   lsu_stall           : hold the pipeline
//   lsu_done            : one-cycle completion pulse
//   lsu_rdata, lsu_err  : load result / misalignment or bad mask, with done
//   bus_req_valid/ready : request handshake
//   bus_addr/wen/wstrb/wdata : request fields
//   bus_rsp_valid/rdata : response (read data or write ack)
// ---------------------------------------------------------------------------
module ysyx_22040088_lsu
  import ysyx_22040088_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ena,
  input  logic        mem_wen,
  input  logic [3:0]  mem_mask,
  input  logic [2:0]  sel_rfres,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [63:0] lsu_rdata,
  output logic        lsu_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [63:0] bus_addr,
  output logic        bus_wen,
  output logic [7:0]  bus_wstrb,
  output logic [63:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [63:0] bus_rdata
);

  lsu_state_e  state;
  logic [2:0]  offset_reg;
  lsu_size_e   size_reg;
  logic        signed_reg;
  logic        wen_reg;
  logic [63:0] addr_reg;
  logic [63:0] wdata_reg;
  logic [63:0] rdata_reg;
  logic        err_reg;
  logic        done_reg;
  logic        req_valid_reg;

  lsu_size_e   req_size;
  logic        req_err;
  logic [7:0]  st_wstrb;
  logic [63:0] st_wdata;
  logic [63:0] ld_result;
  logic        unused_sel;

  // sel_rfres[0] selects the ALU result elsewhere; it has no meaning here.
  assign unused_sel = sel_rfres[0];

  assign req_size = mask_to_size(mem_mask);
  assign req_err  = ~mask_legal(mem_mask) | misaligned(req_size, addr[2:0]);

  // Lane steering works from registered fields, so bus fields stay stable
  // for the whole request phase regardless of what the core does.
  ysyx_22040088_lsu_align u_align (
    .offset    (offset_reg),
    .size      (size_reg),
    .is_signed (signed_reg),
    .st_data   (wdata_reg),
    .st_wstrb  (st_wstrb),
    .st_wdata  (st_wdata),
    .ld_rdata  (bus_rdata),
    .ld_result (ld_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LSU_IDLE;
      offset_reg    <= 3'd0;
      size_reg      <= SIZE_B;
      signed_reg    <= 1'b0;
      wen_reg       <= 1'b0;
      addr_reg      <= 64'd0;
      wdata_reg     <= 64'd0;
      rdata_reg     <= 64'd0;
      err_reg       <= 1'b0;
      done_reg      <= 1'b0;
      req_valid_reg <= 1'b0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (mem_ena) begin
            offset_reg <= addr[2:0];
            size_reg   <= req_size;
            // signed wins if both bits are ever set together
            signed_reg <= sel_rfres[SEL_SIGNED] | ~sel_rfres[SEL_UNSIGNED] & 1'b0;
            // a rejected access never shows write intent on the bus
            wen_reg    <= mem_wen & ~req_err;
            addr_reg   <= {addr[63:3], 3'b000};
            wdata_reg  <= mem_wen ? wdata : 64'd0;
            rdata_reg  <= 64'd0;
            err_reg    <= req_err;
            if (req_err) begin
              done_reg <= 1'b1;
              state    <= LSU_DONE;
            end else begin
              req_valid_reg <= 1'b1;
              state         <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          if (bus_req_ready) begin
            req_valid_reg <= 1'b0;
            state         <= LSU_WAIT;
          end
        end
        LSU_WAIT: begin
          if (bus_rsp_valid) begin
            rdata_reg <= wen_reg ? 64'd0 : ld_result;
            done_reg  <= 1'b1;
            state     <= LSU_DONE;
          end
        end
        LSU_DONE: begin
          done_reg <= 1'b0;
          state    <= LSU_IDLE;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

  assign lsu_stall     = mem_ena & ~done_reg;
  assign lsu_done      = done_reg;
  assign lsu_rdata     = rdata_reg;
  assign lsu_err       = err_reg;
  assign bus_req_valid = req_valid_reg;
  assign bus_addr      = addr_reg;
  assign bus_wen       = wen_reg;
  assign bus_wstrb     = wen_reg ? st_wstrb : 8'h00;
  assign bus_wdata     = st_wdata;

endmodule

// File: tb/tb_ysyx_22040088_lsu.sv
module tb_ysyx_22040088_lsu;

  logic        clk;
  logic        rst_n;
  logic        mem_ena;
  logic        mem_wen;
  logic [3:0]  mem_mask;
  logic [2:0]  sel_rfres;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        lsu_stall;
  logic        lsu_done;
  logic [63:0] lsu_rdata;
  logic        lsu_err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [63:0] bus_addr;
  logic        bus_wen;
  logic [7:0]  bus_wstrb;
  logic [63:0] bus_wdata;
  logic        bus_rsp_valid;
  logic [63:0] bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_22040088_lsu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_ena       (mem_ena),
    .mem_wen       (mem_wen),
    .mem_mask      (mem_mask),
    .sel_rfres     (sel_rfres),
    .addr          (addr),
    .wdata         (wdata),
    .lsu_stall     (lsu_stall),
    .lsu_done      (lsu_done),
    .lsu_rdata     (lsu_rdata),
    .lsu_err       (lsu_err),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_addr      (bus_addr),
    .bus_wen       (bus_wen),
    .bus_wstrb     (bus_wstrb),
    .bus_wdata     (bus_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rdata     (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        wen;
    logic [3:0]  mask;
    logic [2:0]  sel;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [63:0] exp_rdata;
    logic [7:0]  exp_wstrb;
    logic [63:0] exp_wdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input string name, input logic wen, input logic [3:0] mask,
                              input logic [2:0] sel, input logic [63:0] a, input logic [63:0] wd,
                              input logic [63:0] rd, input logic [63:0] erd, input logic [7:0] estrb,
                              input logic [63:0] ewd, input logic eerr);
    vec_t v;
    v.name = name; v.wen = wen; v.mask = mask; v.sel = sel; v.addr = a; v.wdata = wd;
    v.rdata = rd; v.exp_rdata = erd; v.exp_wstrb = estrb; v.exp_wdata = ewd; v.exp_err = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Presents one instruction and plays the bus side. Cycle 1 is the first
  // cycle after the edge that could sample mem_ena; lead adds cycles spent
  // before the FSM is back in IDLE (back-to-back issue from a DONE cycle).
  task automatic run_txn(input vec_t v, input int rdy_dly, input int rsp_dly,
                         input int lead, input bit chain);
    int          exp_done;
    int          done_cyc;
    int          req_cyc;
    int          ready_cnt;
    int          rsp_cnt;
    int          phase;
    bit          stall_ok;
    bit          stable_ok;
    logic [63:0] got_rdata;
    logic        got_err;
    logic [63:0] exp_addr;

    exp_done  = lead + (v.exp_err ? 1 : 3 + rdy_dly + rsp_dly);
    exp_addr  = {v.addr[63:3], 3'b000};
    mem_ena   = 1'b1;
    mem_wen   = v.wen;
    mem_mask  = v.mask;
    sel_rfres = v.sel;
    addr      = v.addr;
    wdata     = v.wdata;
    bus_rdata = v.rdata;
    done_cyc  = -1;
    req_cyc   = -1;
    ready_cnt = 0;
    rsp_cnt   = 0;
    phase     = 0;
    stall_ok  = 1'b1;
    stable_ok = 1'b1;
    got_rdata = '0;
    got_err   = 1'b0;

    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (lsu_done) begin
        done_cyc  = c;
        got_rdata = lsu_rdata;
        got_err   = lsu_err;
        if (lsu_stall !== 1'b0) stall_ok = 1'b0;
      end else if (lsu_stall !== 1'b1) begin
        stall_ok = 1'b0;
      end
      if (bus_req_valid) begin
        if (req_cyc < 0) req_cyc = c;
        if (phase != 0 || bus_addr !== exp_addr || bus_wen !== v.wen ||
            bus_wstrb !== v.exp_wstrb || (v.wen && bus_wdata !== v.exp_wdata))
          stable_ok = 1'b0;
      end
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      if (phase == 0 && bus_req_valid) begin
        if (ready_cnt < rdy_dly) ready_cnt++;
        else begin bus_req_ready = 1'b1; phase = 1; end
      end else if (phase == 1) begin
        if (rsp_cnt < rsp_dly) rsp_cnt++;
        else begin bus_rsp_valid = 1'b1; phase = 2; end
      end
    end
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    if (!chain) mem_ena = 1'b0;

    $display("txn %s: done_cycle=%0d req_cycle=%0d rdata=%h err=%b", v.name, done_cyc,
             req_cyc, got_rdata, got_err);
    chk({v.name, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
    chk({v.name, " lsu_err"}, {63'd0, got_err}, {63'd0, v.exp_err});
    chk({v.name, " stall"}, {63'd0, stall_ok}, 64'd1);
    if (v.exp_err) begin
      chk({v.name, " no_request"}, 64'(req_cyc), 64'(-1));
    end else begin
      chk({v.name, " lsu_rdata"}, got_rdata, v.exp_rdata);
      chk({v.name, " req_cycle"}, 64'(req_cyc), 64'(lead + 1));
      chk({v.name, " req_fields"}, {63'd0, stable_ok}, 64'd1);
    end
  endtask

  task automatic idle_cycle(input string name);
    @(negedge clk);
    chk({name, " done_single"}, {63'd0, lsu_done}, 64'd0);
    chk({name, " idle_no_req"}, {63'd0, bus_req_valid}, 64'd0);
  endtask

  initial begin
    vec_t ldv;
    vec_t sdv;
    vec_t lwuv;

    vecs[0]  = mk("lb",     1'b0, 4'b1000, 3'b010, 64'h8000_0003, 64'd0, 64'h1122_3344_8877_6655,
                  64'hFFFF_FFFF_FFFF_FF88, 8'h00, 64'd0, 1'b0);
    vecs[1]  = mk("lbu",    1'b0, 4'b1000, 3'b100, 64'h8000_0003, 64'd0, 64'h1122_3344_8877_6655,
                  64'h0000_0000_0000_0088, 8'h00, 64'd0, 1'b0);
    vecs[2]  = mk("sw",     1'b1, 4'b0010, 3'b000, 64'h8000_0104, 64'hDEAD_BEEF, 64'h123,
                  64'd0, 8'hF0, 64'hDEAD_BEEF_0000_0000, 1'b0);
    vecs[3]  = mk("lh",     1'b0, 4'b0100, 3'b010, 64'h8000_0006, 64'd0, 64'h8001_0000_0000_0000,
                  64'hFFFF_FFFF_FFFF_8001, 8'h00, 64'd0, 1'b0);
    vecs[4]  = mk("lhu",    1'b0, 4'b0100, 3'b100, 64'h8000_0002, 64'd0, 64'h0000_0000_ABCD_0000,
                  64'h0000_0000_0000_ABCD, 8'h00, 64'd0, 1'b0);
    vecs[5]  = mk("lw_pos", 1'b0, 4'b0010, 3'b010, 64'h8000_0000, 64'd0, 64'hFFFF_FFFF_7FFF_FFFF,
                  64'h0000_0000_7FFF_FFFF, 8'h00, 64'd0, 1'b0);
    vecs[6]  = mk("lw_neg", 1'b0, 4'b0010, 3'b010, 64'h8000_000C, 64'd0, 64'h8765_4321_0000_0000,
                  64'hFFFF_FFFF_8765_4321, 8'h00, 64'd0, 1'b0);
    vecs[7]  = mk("ld",     1'b0, 4'b0001, 3'b010, 64'h8000_0008, 64'd0, 64'h0123_4567_89AB_CDEF,
                  64'h0123_4567_89AB_CDEF, 8'h00, 64'd0, 1'b0);
    vecs[8]  = mk("sb",     1'b1, 4'b1000, 3'b000, 64'h8000_0005, 64'h12A5, 64'h0,
                  64'd0, 8'h20, 64'h0012_A500_0000_0000, 1'b0);
    vecs[9]  = mk("sh",     1'b1, 4'b0100, 3'b000, 64'h8000_0006, 64'hBEEF, 64'h0,
                  64'd0, 8'hC0, 64'hBEEF_0000_0000_0000, 1'b0);
    vecs[10] = mk("sd",     1'b1, 4'b0001, 3'b000, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'h0,
                  64'd0, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0);
    vecs[11] = mk("lh_mis", 1'b0, 4'b0100, 3'b010, 64'h8000_0001, 64'd0, 64'h0,
                  64'd0, 8'h00, 64'd0, 1'b1);
    vecs[12] = mk("mask11", 1'b0, 4'b0011, 3'b010, 64'h8000_0000, 64'd0, 64'h0,
                  64'd0, 8'h00, 64'd0, 1'b1);
    vecs[13] = mk("ld_mis", 1'b0, 4'b0001, 3'b010, 64'h8000_0004, 64'd0, 64'h0,
                  64'd0, 8'h00, 64'd0, 1'b1);
    vecs[14] = mk("sw_mis", 1'b1, 4'b0010, 3'b000, 64'h8000_0102, 64'h1, 64'h0,
                  64'd0, 8'h00, 64'd0, 1'b1);
    vecs[15] = mk("mask00", 1'b0, 4'b0000, 3'b100, 64'h8000_0000, 64'd0, 64'h0,
                  64'd0, 8'h00, 64'd0, 1'b1);

    rst_n = 1'b0; mem_ena = 1'b0; mem_wen = 1'b0; mem_mask = 4'd0; sel_rfres = 3'd0;
    addr = '0; wdata = '0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst lsu_stall", {63'd0, lsu_stall}, 64'd0);
    chk("rst lsu_done", {63'd0, lsu_done}, 64'd0);
    chk("rst lsu_rdata", lsu_rdata, 64'd0);
    chk("rst lsu_err", {63'd0, lsu_err}, 64'd0);
    chk("rst bus_req_valid", {63'd0, bus_req_valid}, 64'd0);
    chk("rst bus_addr", bus_addr, 64'd0);
    chk("rst bus_wstrb", {56'd0, bus_wstrb}, 64'd0);
    chk("rst bus_wdata", bus_wdata, 64'd0);
    mem_ena = 1'b1;
    #1;
    chk("rst stall_follows_ena", {63'd0, lsu_stall}, 64'd1);
    mem_ena = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of single accesses, ready immediately, response one cycle later
    for (int i = 0; i < 16; i++) begin
      run_txn(vecs[i], 0, 0, 0, 1'b0);
      idle_cycle(vecs[i].name);
    end

    // Request held off 5 cycles, response 3 more cycles late
    ldv = vecs[7];
    ldv.name = "ld_slow";
    run_txn(ldv, 5, 3, 0, 1'b0);
    idle_cycle("ld_slow");

    // Back-to-back sd then lwu: next instruction presented during DONE
    sdv  = mk("b2b_sd",  1'b1, 4'b0001, 3'b000, 64'h8000_0020, 64'hCAFE_F00D_1234_5678, 64'h0,
              64'd0, 8'hFF, 64'hCAFE_F00D_1234_5678, 1'b0);
    lwuv = mk("b2b_lwu", 1'b0, 4'b0010, 3'b100, 64'h8000_0024, 64'd0, 64'h8000_0001_DEAD_BEEF,
              64'h0000_0000_8000_0001, 8'h00, 64'd0, 1'b0);
    run_txn(sdv, 0, 0, 0, 1'b1);
    run_txn(lwuv, 0, 0, 1, 1'b0);
    idle_cycle("b2b_lwu");

    // Reset asserted while waiting for a response
    mem_ena = 1'b1; mem_wen = 1'b0; mem_mask = 4'b0001; sel_rfres = 3'b010;
    addr = 64'h8000_0040; wdata = '0; bus_rdata = 64'h5555_5555_5555_5555;
    @(negedge clk);
    chk("rstwait req_valid", {63'd0, bus_req_valid}, 64'd1);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    chk("rstwait in_wait", {63'd0, bus_req_valid}, 64'd0);
    rst_n = 1'b0;
    mem_ena = 1'b0;
    #1;
    chk("rstwait bus_addr", bus_addr, 64'd0);
    chk("rstwait lsu_done", {63'd0, lsu_done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_rsp_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stray_rsp lsu_done", {63'd0, lsu_done}, 64'd0);
      chk("stray_rsp lsu_rdata", lsu_rdata, 64'd0);
      chk("stray_rsp bus_req_valid", {63'd0, bus_req_valid}, 64'd0);
      chk("stray_rsp lsu_stall", {63'd0, lsu_stall}, 64'd0);
    end
    bus_rsp_valid = 1'b0;
    $display("txn reset_in_wait: stray response ignored check complete");

    // FSM must be in IDLE: a fresh access finishes with minimum latency
    ldv = vecs[0];
    ldv.name = "lb_after_rst";
    run_txn(ldv, 0, 0, 0, 1'b0);
    idle_cycle("lb_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
